// File: rtl/date_edit_ctrl_pkg.sv
// Shared types and constants for the date editor.
// DATE_MONTH_CLAMP_EN adds the month-length helper used for day limiting.
package date_edit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [3:0] CUR_NONE = 4'd0;
    localparam logic [3:0] CUR_DAY  = 4'd3;
    localparam logic [3:0] CUR_MON  = 4'd4;
    localparam logic [3:0] CUR_YEAR = 4'd5;

    localparam logic [7:0] DAY_MIN  = 8'h01;
    localparam logic [7:0] DAY_MAX  = 8'h31;
    localparam logic [7:0] MON_MIN  = 8'h01;
    localparam logic [7:0] MON_MAX  = 8'h12;
    localparam logic [7:0] YEAR_MIN = 8'h00;
    localparam logic [7:0] YEAR_MAX = 8'h99;

`ifdef DATE_MONTH_CLAMP_EN
    // Leap test on BCD: 10*t+u is a multiple of 4 iff (2*t+u) is.
    function automatic logic [7:0] month_len(input logic [7:0] mon, input logic [7:0] year);
        logic leap;
        if (year[4])
            leap = (year[3:0] == 4'd2) || (year[3:0] == 4'd6);
        else
            leap = (year[3:0] == 4'd0) || (year[3:0] == 4'd4) || (year[3:0] == 4'd8);
        case (mon)
            8'h04, 8'h06, 8'h09, 8'h11: month_len = 8'h30;
            8'h02:                      month_len = leap ? 8'h29 : 8'h28;
            default:                    month_len = 8'h31;
        endcase
    endfunction
`endif

endpackage

// File: rtl/date_edit_ctrl_bcd_field_step.sv
// Combinational BCD up/down step of one date field with wrap; any value outside
// [min,max] or with a nibble above 9 wraps to min on up and to max on down.
module bcd_field_step (
    input  logic [7:0] value,
    input  logic [7:0] min,
    input  logic [7:0] max,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] next
);

    logic in_range;

    always_comb begin
        in_range = (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) &&
                   (value >= min) && (value <= max);
        next = value;
        if (inc && !dec) begin
            if (!in_range || value == max)
                next = min;
            else if (value[3:0] == 4'd9)
                next = {value[7:4] + 4'd1, 4'd0};
            else
                next = {value[7:4], value[3:0] + 4'd1};
        end else if (dec && !inc) begin
            if (!in_range || value == min)
                next = max;
            else if (value[3:0] == 4'd0)
                next = {value[7:4] - 4'd1, 4'd9};
            else
                next = {value[7:4], value[3:0] - 4'd1};
        end
    end

endmodule

// File: rtl/date_edit_ctrl.sv
// Date field editor feeding the on-screen date painter, with RTC write-back on exit.
// Define DATE_MONTH_CLAMP_EN to limit the day to the length of the selected month.
module date_edit_ctrl
    import date_edit_pkg::*;
#(
    parameter int         WR_TIMEOUT = 1023,
    parameter logic [7:0] DAY_RST    = 8'h01,
    parameter logic [7:0] MON_RST    = 8'h01,
    parameter logic [7:0] YEAR_RST   = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        prog_toggle,
    input  logic        rtc_valid,
    input  logic [7:0]  rtc_day,
    input  logic [7:0]  rtc_mon,
    input  logic [7:0]  rtc_year,
    input  logic        wr_ack,
    output logic [7:0]  fecha_out1,
    output logic [7:0]  fecha_out2,
    output logic [7:0]  fecha_out3,
    output logic        programar_on,
    output logic [3:0]  direccion_actual_pantalla,
    output logic        wr_req,
    output logic [23:0] wr_data,
    output logic        wr_err
);

    state_t state;
    logic [9:0] wr_cnt;

    // Field index 0 = day, 1 = month, 2 = year.
    logic [2:0][7:0] fld, fld_min, fld_max, fld_nxt;
    logic [2:0]      fld_inc, fld_dec;
    logic            step_en;
    logic [7:0]      day_max, day_next;

    assign fld     = {fecha_out3, fecha_out2, fecha_out1};
    assign fld_min = {YEAR_MIN, MON_MIN, DAY_MIN};
    assign fld_max = {YEAR_MAX, MON_MAX, day_max};
    assign step_en = (state == ST_EDIT) && !prog_toggle;

`ifdef DATE_MONTH_CLAMP_EN
    logic [7:0] day_lim;
    logic       my_changed;
    assign day_max    = month_len(fecha_out2, fecha_out3);
    assign day_lim    = month_len(fld_nxt[1], fld_nxt[2]);
    assign my_changed = (fld_nxt[1] != fecha_out2) || (fld_nxt[2] != fecha_out3);
    assign day_next   = (my_changed && fld_nxt[0] > day_lim) ? day_lim : fld_nxt[0];
`else
    assign day_max  = DAY_MAX;
    assign day_next = fld_nxt[0];
`endif

    for (genvar i = 0; i < 3; i++) begin : g_step
        localparam logic [3:0] CUR_I = CUR_DAY + 4'(i);
        assign fld_inc[i] = step_en && btn_up   && (direccion_actual_pantalla == CUR_I);
        assign fld_dec[i] = step_en && btn_down && (direccion_actual_pantalla == CUR_I);
        bcd_field_step u_step (
            .value (fld[i]),
            .min   (fld_min[i]),
            .max   (fld_max[i]),
            .inc   (fld_inc[i]),
            .dec   (fld_dec[i]),
            .next  (fld_nxt[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                     <= ST_IDLE;
            fecha_out1                <= DAY_RST;
            fecha_out2                <= MON_RST;
            fecha_out3                <= YEAR_RST;
            programar_on              <= 1'b0;
            direccion_actual_pantalla <= CUR_NONE;
            wr_req                    <= 1'b0;
            wr_data                   <= '0;
            wr_err                    <= 1'b0;
            wr_cnt                    <= '0;
        end else begin
            wr_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rtc_valid) begin
                        fecha_out1 <= rtc_day;
                        fecha_out2 <= rtc_mon;
                        fecha_out3 <= rtc_year;
                    end
                    if (prog_toggle) begin
                        state                     <= ST_EDIT;
                        programar_on              <= 1'b1;
                        direccion_actual_pantalla <= CUR_DAY;
                    end
                end
                ST_EDIT: begin
                    if (prog_toggle) begin
                        state   <= ST_COMMIT;
                        wr_req  <= 1'b1;
                        wr_data <= {fecha_out1, fecha_out2, fecha_out3};
                        wr_cnt  <= '0;
                    end else begin
                        fecha_out1 <= day_next;
                        fecha_out2 <= fld_nxt[1];
                        fecha_out3 <= fld_nxt[2];
                        // Cursor moves after the step, so the step used the old field.
                        if (btn_right && !btn_left)
                            direccion_actual_pantalla <= (direccion_actual_pantalla == CUR_YEAR) ?
                                CUR_DAY : direccion_actual_pantalla + 4'd1;
                        else if (btn_left && !btn_right)
                            direccion_actual_pantalla <= (direccion_actual_pantalla == CUR_DAY) ?
                                CUR_YEAR : direccion_actual_pantalla - 4'd1;
                    end
                end
                ST_COMMIT: begin
                    if (wr_ack || wr_cnt == 10'(WR_TIMEOUT - 1)) begin
                        state                     <= ST_IDLE;
                        wr_req                    <= 1'b0;
                        wr_err                    <= !wr_ack;
                        programar_on              <= 1'b0;
                        direccion_actual_pantalla <= CUR_NONE;
                    end else begin
                        wr_cnt <= wr_cnt + 10'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
